// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request and fills IF/ID.
// Define IF_PERF_CNT_EN to add the fetched/bubble performance counter outputs.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_IF_imem_req,
    output logic [31:0] o_IF_imem_addr,
    input  logic        i_IF_imem_ack,
    input  logic [31:0] i_IF_imem_rdata,
    input  logic        i_IF_ctrl_Stall,
    input  logic        i_IF_ctrl_Redirect,
    input  logic [31:0] i_IF_data_Target,
    output logic [31:0] o_ID_data_instruction,
    output logic        o_ID_data_valid,
    output logic [31:0] o_EX_data_PCNext
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] o_IF_perf_Fetched,
    output logic [31:0] o_IF_perf_Bubble
`endif
);

    typedef enum logic [1:0] {StReq, StFull, StDrop} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcnext_q, pcnext_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pcnext_q, skid_pcnext_d;

    logic [31:0] target_al;
    logic [31:0] pc_plus4;
    logic        slot_free;
    logic        load_valid;

    assign target_al = i_IF_data_Target & 32'hFFFF_FFFC;
    assign pc_plus4  = pc_q + 32'd4;
    assign slot_free = !valid_q || !i_IF_ctrl_Stall;

    // The request is suppressed while rst is high, whatever the stale state.
    assign o_IF_imem_req         = !rst && (state_q == StReq || state_q == StDrop);
    assign o_IF_imem_addr        = pc_q;
    assign o_ID_data_instruction = instr_q;
    assign o_ID_data_valid       = valid_q;
    assign o_EX_data_PCNext      = pcnext_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pending_d     = pending_q;
        instr_d       = instr_q;
        pcnext_d      = pcnext_q;
        valid_d       = valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pcnext_d = skid_pcnext_q;
        load_valid    = 1'b0;

        // Default bubble when ID consumes and nothing new arrives.
        if (!i_IF_ctrl_Stall) begin
            valid_d = 1'b0;
            instr_d = 32'h0;
        end

        unique case (state_q)
            StReq: begin
                if (i_IF_imem_ack && !i_IF_ctrl_Redirect) begin
                    pc_d = pc_plus4;
                    if (slot_free) begin
                        instr_d    = i_IF_imem_rdata;
                        pcnext_d   = pc_plus4;
                        valid_d    = 1'b1;
                        load_valid = 1'b1;
                    end else begin
                        skid_instr_d  = i_IF_imem_rdata;
                        skid_pcnext_d = pc_plus4;
                        state_d       = StFull;
                    end
                end else if (i_IF_imem_ack && i_IF_ctrl_Redirect) begin
                    pc_d = target_al;
                end else if (i_IF_ctrl_Redirect) begin
                    pending_d = target_al;
                    state_d   = StDrop;
                end
            end
            StFull: begin
                if (i_IF_ctrl_Redirect) begin
                    skid_instr_d  = 32'h0;
                    skid_pcnext_d = 32'h0;
                    pc_d          = target_al;
                    state_d       = StReq;
                end else if (!i_IF_ctrl_Stall) begin
                    instr_d    = skid_instr_q;
                    pcnext_d   = skid_pcnext_q;
                    valid_d    = 1'b1;
                    load_valid = 1'b1;
                    state_d    = StReq;
                end
            end
            StDrop: begin
                // A redirect coinciding with the ack is the most recent target.
                if (i_IF_imem_ack) begin
                    pc_d    = i_IF_ctrl_Redirect ? target_al : pending_q;
                    state_d = StReq;
                end else if (i_IF_ctrl_Redirect) begin
                    pending_d = target_al;
                end
            end
            default: state_d = StReq;
        endcase

        if (i_IF_ctrl_Redirect) begin
            valid_d    = 1'b0;
            instr_d    = 32'h0;
            pcnext_d   = 32'h0;
            load_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StReq;
            pc_q          <= RESET_PC & 32'hFFFF_FFFC;
            pending_q     <= 32'h0;
            instr_q       <= 32'h0;
            pcnext_q      <= 32'h0;
            valid_q       <= 1'b0;
            skid_instr_q  <= 32'h0;
            skid_pcnext_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pending_q     <= pending_d;
            instr_q       <= instr_d;
            pcnext_q      <= pcnext_d;
            valid_q       <= valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pcnext_q <= skid_pcnext_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] bubble_q, bubble_d;

    always_comb begin
        fetched_d = fetched_q;
        bubble_d  = bubble_q;
        if (load_valid) begin
            fetched_d = fetched_q + 32'd1;
        end
        if (!i_IF_ctrl_Stall && !valid_d) begin
            bubble_d = bubble_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= 32'h0;
            bubble_q  <= 32'h0;
        end else begin
            fetched_q <= fetched_d;
            bubble_q  <= bubble_d;
        end
    end

    assign o_IF_perf_Fetched = fetched_q;
    assign o_IF_perf_Bubble  = bubble_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; imem returns {16'hC0DE, addr[15:0]} so words identify their PC.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] pcnext;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubble;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rdata = {16'hC0DE, addr[15:0]};

    if_fetch_stage #(
        .RESET_PC(32'h0000_0040)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .o_IF_imem_req        (req),
        .o_IF_imem_addr       (addr),
        .i_IF_imem_ack        (ack),
        .i_IF_imem_rdata      (rdata),
        .i_IF_ctrl_Stall      (stall),
        .i_IF_ctrl_Redirect   (redirect),
        .i_IF_data_Target     (target),
        .o_ID_data_instruction(instr),
        .o_ID_data_valid      (valid),
        .o_EX_data_PCNext     (pcnext)
`ifdef IF_PERF_CNT_EN
        ,
        .o_IF_perf_Fetched    (perf_fetched),
        .o_IF_perf_Bubble     (perf_bubble)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] i,
                            input logic [31:0] pn);
        chk({tag, ".valid"}, {31'h0, valid}, {31'h0, v});
        chk({tag, ".instr"}, instr, i);
        chk({tag, ".pcnext"}, pcnext, pn);
    endtask

    initial begin
        rst = 1'b1; ack = 1'b0; stall = 1'b0; redirect = 1'b0; target = 32'h0;
        step();
        step();
        chk("rst.req", {31'h0, req}, 32'h0);
        chk_ifid("rst", 1'b0, 32'h0, 32'h0);

        // Back-to-back fetches with a same-cycle ack
        rst = 1'b0; ack = 1'b1;
        #1;
        chk("seq.req0", {31'h0, req}, 32'h1);
        chk("seq.addr0", addr, 32'h40);
        step();
        chk_ifid("seq1", 1'b1, 32'hC0DE_0040, 32'h44);
        chk("seq.addr1", addr, 32'h44);
        step();
        chk_ifid("seq2", 1'b1, 32'hC0DE_0044, 32'h48);
        chk("seq.addr2", addr, 32'h48);
        step();
        chk_ifid("seq3", 1'b1, 32'hC0DE_0048, 32'h4C);
        chk("seq.addr3", addr, 32'h4C);

        // Stall with a live IF/ID while 0x4C is acked: word goes to the skid
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ifid("stall", 1'b1, 32'hC0DE_0048, 32'h4C);
            chk("stall.req", {31'h0, req}, 32'h0);
        end
        stall = 1'b0;
        step();
        chk_ifid("skid", 1'b1, 32'hC0DE_004C, 32'h50);
        chk("skid.req", {31'h0, req}, 32'h1);
        chk("skid.addr", addr, 32'h50);

        // Redirect coinciding with ack at 0x50
        redirect = 1'b1; target = 32'h100;
        step();
        chk_ifid("redir_ack", 1'b0, 32'h0, 32'h0);
        chk("redir_ack.addr", addr, 32'h100);
        redirect = 1'b0;
        step();
        chk_ifid("after_redir", 1'b1, 32'hC0DE_0100, 32'h104);

        // Move to 0x60, then redirect while the request there is unacked
        redirect = 1'b1; target = 32'h60;
        step();
        chk("to60.addr", addr, 32'h60);
        ack = 1'b0; target = 32'h200;
        step();
        chk("drop.addr", addr, 32'h60);
        chk("drop.valid", {31'h0, valid}, 32'h0);
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("drop.hold_addr", addr, 32'h60);
            chk("drop.hold_req", {31'h0, req}, 32'h1);
        end
        ack = 1'b1;
        step();
        chk("drop.discard", {31'h0, valid}, 32'h0);
        chk("drop.new_addr", addr, 32'h200);
        ack = 1'b0;
        step();
        chk("drop.wait_addr", addr, 32'h200);
        chk("drop.bubble", {31'h0, valid}, 32'h0);

        // PC wrap at the top of the address space
        ack = 1'b1; redirect = 1'b1; target = 32'hFFFF_FFFC;
        step();
        chk("wrap.addr", addr, 32'hFFFF_FFFC);
        redirect = 1'b0;
        step();
        chk_ifid("wrap", 1'b1, 32'hC0DE_FFFC, 32'h0);
        chk("wrap.next_addr", addr, 32'h0);

        // Misaligned target is aligned down
        redirect = 1'b1; target = 32'h103;
        step();
        chk("align.addr", addr, 32'h100);
        redirect = 1'b0;
        step();
        chk_ifid("align", 1'b1, 32'hC0DE_0100, 32'h104);

        // Redirect while parked in the skid
        stall = 1'b1;
        step();
        chk("full.req", {31'h0, req}, 32'h0);
        redirect = 1'b1; target = 32'h300;
        step();
        chk_ifid("full_redir", 1'b0, 32'h0, 32'h0);
        chk("full_redir.addr", addr, 32'h300);
        redirect = 1'b0; stall = 1'b0;
        step();
        chk_ifid("full_after", 1'b1, 32'hC0DE_0300, 32'h304);

        // Reset mid-run
        rst = 1'b1;
        step();
        chk("rst2.req", {31'h0, req}, 32'h0);
        chk_ifid("rst2", 1'b0, 32'h0, 32'h0);

`ifdef IF_PERF_CNT_EN
        chk("perf.rst_fetched", perf_fetched, 32'h0);
        chk("perf.rst_bubble", perf_bubble, 32'h0);
        rst = 1'b0; ack = 1'b1;
        for (int i = 0; i < 5; i++) step();
        ack = 1'b0;
        for (int i = 0; i < 2; i++) step();
        ack = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("perf.fetched", perf_fetched, 32'd10);
        chk("perf.bubble", perf_bubble, 32'd2);
        rst = 1'b1;
        step();
        chk("perf.rst2_fetched", perf_fetched, 32'h0);
        chk("perf.rst2_bubble", perf_bubble, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage. It owns the PC, issues single-outstanding requests to instruction memory, and maintains the IF/ID pipeline register.
- It supplies ID with the instruction word and the bypassed PC+4 that ID forwards to EX.
- It accepts stall from the hazard unit and PC redirects (branch/jump/jr) resolved in EX.
- It sits between the instruction memory and the ID decoder.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- o_IF_imem_req  out  1  fetch request; held until acked.
- o_IF_imem_addr  out  32  fetch address; word aligned, stable while req=1.
- i_IF_imem_ack  in  1  response strobe; rdata valid this cycle.
- i_IF_imem_rdata  in  32  instruction word.
- i_IF_ctrl_Stall  in  1  hold IF/ID contents; ID not consuming.
- i_IF_ctrl_Redirect  in  1  take new PC (branch taken / jump / jr).
- i_IF_data_Target  in  32  redirect target PC.
- o_ID_data_instruction  out  32  IF/ID instruction; 32'h0 (NOP) when invalid.
- o_ID_data_valid  out  1  IF/ID holds a live instruction.
- o_EX_data_PCNext  out  32  PC+4 of the IF/ID instruction (bypassed through ID).

Behaviour:
- Reset:
  - pc=RESET_PC, state=S_REQ, req=0 during the reset cycle.
  - valid=0, instruction=0, PCNext=0, skid empty, pending target=0.
- States:
  - S_REQ: req=1, addr=pc.
  - S_FULL: req=0; the skid buffer holds a fetched word awaiting an IF/ID slot.
  - S_DROP: req=1 with the old address; the response will be discarded.
- IF/ID slot is free when valid=0 or Stall=0.
- S_REQ transitions:
  - ack & !Redirect & slot free: IF/ID <= {rdata, pc+4}, valid<=1, pc<=pc+4, stay S_REQ. Next request issues the following cycle; max throughput is 1 instruction per cycle when ack is combinational same-cycle.
  - ack & !Redirect & !slot free: skid <= {rdata, pc+4}, pc<=pc+4, go to S_FULL.
  - ack & Redirect: discard rdata, pc<=Target, stay S_REQ.
  - !ack & Redirect: pending<=Target, go to S_DROP. The address is not changed mid-request.
- S_FULL transitions:
  - !Stall & !Redirect: IF/ID <= skid, valid<=1, go to S_REQ.
  - Redirect: skid cleared, pc<=Target, go to S_REQ.
- S_DROP transitions:
  - On ack: discard rdata, pc<=pending, go to S_REQ.
  - A further Redirect in S_DROP overwrites pending (last wins).
- Redirect priority:
  - Redirect beats Stall.
  - Redirect clears IF/ID in the same edge: valid<=0, instruction<=0, PCNext<=0.
  - No delay slot.
- Stall without Redirect: IF/ID holds all fields unchanged.
- If !Stall and no new word is loaded, valid<=0 and instruction<=0 (bubble).
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. Target[1:0] is ignored; addr[1:0] is always 2'b00.
- Simultaneous ack + Stall + valid=1 in S_REQ: the word goes to the skid, never lost and never duplicated.
- rst asserted in any state overrides everything in that cycle. An outstanding imem response arriving after reset is ignored only if ack arrives while rst=1; the imem must not ack a request dropped by reset.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- With the macro, ports o_IF_perf_Fetched[31:0] and o_IF_perf_Bubble[31:0] exist:
  - Fetched increments on each IF/ID load with valid<=1.
  - Bubble increments each cycle where Stall=0 and IF/ID loads valid=0.
  - Both are reset to 0 and wrap at 2^32.
- Without the macro, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, RESET_PC=32'h0000_0040, ack always 1, no stall -> addrs 0x40, 0x44, 0x48 on consecutive requests; IF/ID shows the matching instructions with PCNext 0x44, 0x48, 0x4C; valid=1 from the second post-reset cycle.
- Stall=1 for 3 cycles while valid=1 and ack arrives -> IF/ID frozen, word parked in skid, req=0. Stall drops -> skid word appears next cycle with PCNext = previous+4. No instruction lost or duplicated.
- Redirect to 0x100 with the request at 0x50 acked the same cycle -> 0x50 word discarded, valid=0 next cycle, next addr=0x100.
- Redirect to 0x200 while the request at 0x60 is unacked (ack delayed 4 cycles) -> addr stays 0x60 until ack; data discarded; next req addr=0x200.
- pc=32'hFFFF_FFFC fetch -> PCNext=0, next addr=0x0. Redirect with Target=0x103 -> addr 0x100.
- (IF_PERF_CNT_EN) 10 fetches with 2 bubble cycles -> Fetched=10, Bubble=2. Reset -> both 0.
